// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU request sequencer/arbiter.
package alu_ctrl_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_MAX = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   sel;
    } alu_req_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] sel);
        return sel <= OP_W'(OP_MAX);
    endfunction

endpackage

// File: rtl/alu_request_arbiter_rr.sv
// Two-input round-robin grant; last_grant advances only on the update strobe.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    // Contention goes to the requester that did not win last time.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (i_update) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/alu_request_arbiter.sv
// Sequences round-robin-arbitrated requests through the ALU and returns
// the sampled result on a single tagged response channel.
module alu_request_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [DATA_W-1:0] alu_in_2,
    output logic [OP_W-1:0]   alu_sel,
    output logic              alu_en,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_alu_in_1;
    logic [DATA_W-1:0] r_alu_in_2;
    logic [OP_W-1:0]   r_alu_sel;
    logic              r_alu_en;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_id;
    logic              r_rsp_err;
    logic              r_busy;

    logic [1:0]        w_grant;
    logic              w_idle;
    logic              w_accept;
    logic              w_win_id;
    alu_req_t          w_req;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    ({req1_valid, req0_valid}),
        .i_update (w_accept),
        .o_grant  (w_grant)
    );

    // Ready is masked during reset so every output reads 0 while rst is high.
    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign req0_ready = w_grant[0] && w_idle;
    assign req1_ready = w_grant[1] && w_idle;
    assign w_accept   = req0_ready || req1_ready;
    assign w_win_id   = req1_ready;

    always_comb begin
        w_req = '{a: req0_a, b: req0_b, sel: req0_sel};
        if (w_win_id) begin
            w_req = '{a: req1_a, b: req1_b, sel: req1_sel};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_alu_in_1  <= '0;
            r_alu_in_2  <= '0;
            r_alu_sel   <= '0;
            r_alu_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rsp_id <= w_win_id;
                        r_busy   <= 1'b1;
                        if (op_is_legal(w_req.sel)) begin
                            r_alu_in_1 <= w_req.a;
                            r_alu_in_2 <= w_req.b;
                            r_alu_sel  <= w_req.sel;
                            r_alu_en   <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ST_EXEC;
                        end else begin
                            // Illegal opcode bypasses the ALU entirely.
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == LP_LAST) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_alu_en    <= 1'b0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_alu_en    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_in_1  = r_alu_in_1;
    assign alu_in_2  = r_alu_in_2;
    assign alu_sel   = r_alu_sel;
    assign alu_en    = r_alu_en;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter with an XOR ALU stub; two instances
// cover SETTLE_CYCLES=1 and SETTLE_CYCLES=3.
module tb_alu_request_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // SETTLE_CYCLES = 1 instance
    logic       rst, r0v, r1v, rsp_ready;
    logic [3:0] r0a, r0b, r1a, r1b;
    logic [2:0] r0s, r1s;
    logic       r0rdy, r1rdy, rsp_valid, rsp_id, rsp_err, aen, busy;
    logic [3:0] rsp_data, a1, a2, aout;
    logic [2:0] asel;
    assign aout = aen ? (a1 ^ a2) : 4'd0;

    alu_request_arbiter #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_sel(r0s),
        .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_sel(r1s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .alu_in_1(a1), .alu_in_2(a2), .alu_sel(asel), .alu_en(aen),
        .alu_out(aout), .busy(busy)
    );

    // SETTLE_CYCLES = 3 instance
    logic       rst3, r0v3, r1v3, rsp_ready3;
    logic [3:0] r0a3, r0b3, r1a3, r1b3;
    logic [2:0] r0s3, r1s3;
    logic       r0rdy3, r1rdy3, rsp_valid3, rsp_id3, rsp_err3, aen3, busy3;
    logic [3:0] rsp_data3, a13, a23, aout3;
    logic [2:0] asel3;
    assign aout3 = aen3 ? (a13 ^ a23) : 4'd0;

    alu_request_arbiter #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3),
        .req0_valid(r0v3), .req0_ready(r0rdy3), .req0_a(r0a3), .req0_b(r0b3), .req0_sel(r0s3),
        .req1_valid(r1v3), .req1_ready(r1rdy3), .req1_a(r1a3), .req1_b(r1b3), .req1_sel(r1s3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .rsp_id(rsp_id3), .rsp_err(rsp_err3),
        .alu_in_1(a13), .alu_in_2(a23), .alu_sel(asel3), .alu_en(aen3),
        .alu_out(aout3), .busy(busy3)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; r0v = 0; r1v = 0; rsp_ready = 0;
        r0a = 0; r0b = 0; r0s = 0; r1a = 0; r1b = 0; r1s = 0;
        rst3 = 1'b1; r0v3 = 0; r1v3 = 0; rsp_ready3 = 0;
        r0a3 = 0; r0b3 = 0; r0s3 = 0; r1a3 = 0; r1b3 = 0; r1s3 = 0;
        step(); step();
        check("reset_outs", 32'({r0rdy, r1rdy, rsp_valid, rsp_data, rsp_id, rsp_err,
                                 a1, a2, asel, aen, busy}), 32'd0);
        rst = 1'b0;
        step();

        // Single request from req0: 7 ^ 5 = 2
        r0v = 1; r0a = 4'd7; r0b = 4'd5; r0s = 3'd0; rsp_ready = 1;
        #1;
        check("a_ready0", 32'(r0rdy), 32'd1);
        check("a_ready1", 32'(r1rdy), 32'd0);
        step();
        r0v = 0;
        check("a_en", 32'(aen), 32'd1);
        check("a_busy", 32'(busy), 32'd1);
        check("a_in1", 32'(a1), 32'd7);
        check("a_ready0_exec", 32'(r0rdy), 32'd0);
        step();
        check("a_rsp", 32'({rsp_valid, rsp_data, rsp_id, rsp_err}), 32'({1'b1, 4'd2, 1'b0, 1'b0}));
        check("a_en_off", 32'(aen), 32'd0);
        step();
        check("a_idle", 32'({busy, rsp_valid}), 32'd0);

        // Reset during EXEC with a valid request pending
        r0v = 1; r0a = 4'd1; r0b = 4'd2; r0s = 3'd0;
        #1;
        step();
        check("r_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("r_outs", 32'({r0rdy, r1rdy, rsp_valid, rsp_data, rsp_id, rsp_err,
                             a1, a2, asel, aen, busy}), 32'd0);
        r0v = 0;
        step();
        rst = 1'b0;
        step();
        check("r_no_rsp", 32'(rsp_valid), 32'd0);

        // Contention: grants alternate 0,1,0,1, one accept every 3 cycles
        r0v = 1; r0a = 4'd12; r0b = 4'd1;  r0s = 3'd1;
        r1v = 1; r1a = 4'd5;  r1b = 4'd10; r1s = 3'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("b_ready0", 32'(r0rdy), 32'((k % 2) == 0));
            check("b_ready1", 32'(r1rdy), 32'((k % 2) == 1));
            step();
            check("b_en", 32'(aen), 32'd1);
            check("b_in1", 32'(a1), ((k % 2) == 0) ? 32'd12 : 32'd5);
            step();
            check("b_rsp", 32'({rsp_valid, rsp_data, rsp_id}),
                  ((k % 2) == 0) ? 32'({1'b1, 4'd13, 1'b0}) : 32'({1'b1, 4'd15, 1'b1}));
            step();
            check("b_idle", 32'(busy), 32'd0);
        end
        r0v = 0; r1v = 0;

        // Response back-pressure: 10 ^ 8 = 2 held while req1 waits
        r0v = 1; r0a = 4'd10; r0b = 4'd8; r0s = 3'd2; rsp_ready = 0;
        #1;
        check("c_ready0", 32'(r0rdy), 32'd1);
        step();
        r0v = 0;
        step();
        r1v = 1; r1a = 4'd6; r1b = 4'd3; r1s = 3'd1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("c_hold_rsp", 32'({rsp_valid, rsp_data}), 32'({1'b1, 4'd2}));
            check("c_hold_ready", 32'({r0rdy, r1rdy}), 32'd0);
            step();
        end
        rsp_ready = 1;
        step();
        check("c_ready1_after", 32'(r1rdy), 32'd1);
        step();
        r1v = 0;
        step();
        check("c_rsp2", 32'({rsp_valid, rsp_data, rsp_id, rsp_err}), 32'({1'b1, 4'd5, 1'b1, 1'b0}));
        step();

        // Illegal opcode from req1
        rsp_ready = 0;
        r1v = 1; r1a = 4'd15; r1b = 4'd15; r1s = 3'd5;
        #1;
        check("d_ready1", 32'(r1rdy), 32'd1);
        step();
        r1v = 0;
        check("d_en_n", 32'(aen), 32'd0);
        step();
        check("d_rsp", 32'({rsp_valid, rsp_data, rsp_id, rsp_err}), 32'({1'b1, 4'd0, 1'b1, 1'b1}));
        check("d_en_n1", 32'(aen), 32'd0);
        check("d_alu_kept", 32'({a1, a2, asel}), 32'({4'd6, 4'd3, 3'd1}));
        rsp_ready = 1;
        step();
        check("d_idle", 32'(busy), 32'd0);

        // SETTLE_CYCLES = 3: reset in second EXEC cycle, then req1-only op
        rst3 = 1'b0; rsp_ready3 = 1;
        step();
        r0v3 = 1; r0a3 = 4'd9; r0b3 = 4'd3; r0s3 = 3'd0;
        #1;
        step();
        check("e_en_c1", 32'({aen3, busy3}), 32'd3);
        step();
        check("e_en_c2", 32'({aen3, busy3}), 32'd3);
        rst3 = 1'b1;
        #1;
        check("e_abort", 32'({aen3, busy3, rsp_valid3, r0rdy3}), 32'd0);
        r0v3 = 0;
        step();
        rst3 = 1'b0;
        step(); step();
        check("e_no_rsp", 32'({rsp_valid3, busy3}), 32'd0);
        r1v3 = 1; r1a3 = 4'd4; r1b3 = 4'd1; r1s3 = 3'd0;
        #1;
        check("e_ready1", 32'(r1rdy3), 32'd1);
        step();
        r1v3 = 0;
        for (int i = 0; i < 3; i++) begin
            check("e_en_window", 32'({aen3, rsp_valid3}), 32'd2);
            step();
        end
        check("e_rsp", 32'({rsp_valid3, rsp_data3, rsp_id3, rsp_err3}), 32'({1'b1, 4'd5, 1'b1, 1'b0}));
        check("e_en_off", 32'(aen3), 32'd0);
        step();
        check("e_idle", 32'(busy3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_request_arbiter.md
# alu_request_arbiter

Sequencer and two-way arbiter in front of the 4-bit ALU/7-segment datapath (`in_1`, `in_2`, `sel`, `En`, `out`). It accepts operation requests from two requesters over valid/ready handshakes and grants one per operation, round-robin. It drives the ALU operands and enable, samples the result after a settle window, and returns it on a single response channel tagged with the requester id.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 1: cycles the ALU is enabled before its result is sampled; legal range 1–15.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle when high with valid.
- `req0_a`, `req0_b`  in  4 each  requester 0 operands.
- `req0_sel`  in  3  requester 0 opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  4  ALU result.
- `rsp_id`  out  1  originating requester.
- `rsp_err`  out  1  opcode was illegal; no ALU operation ran.
- `alu_in_1`, `alu_in_2`  out  4 each  operands to the ALU.
- `alu_sel`  out  3  opcode to the ALU.
- `alu_en`  out  1  ALU enable.
- `alu_out`  in  4  ALU result.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- States:
  - IDLE: waiting for a request.
  - EXEC: ALU enabled and counting the settle window.
  - RESP: response held until consumed.
- IDLE:
  - If any `reqN_valid` is high, the arbiter picks a winner.
  - The winner's `reqN_ready` is driven high combinationally. The other requester's ready stays low.
  - On the edge with valid and ready, operands, opcode and id are latched, and `last_grant` is set to the winner.
- Arbitration:
  - A lone valid always wins.
  - If both are valid, the requester not equal to `last_grant` wins.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- Legal opcodes are 0–3.
- Accept with a legal opcode:
  - Next state is EXEC, with the counter cleared.
  - `alu_in_1`, `alu_in_2` and `alu_sel` are registered from the latched payload. `alu_en` is high only in EXEC.
- Accept with an opcode of 4–7:
  - Next state is RESP with `rsp_err`=1 and `rsp_data`=0.
  - The ALU outputs are not updated and `alu_en` stays low.
- EXEC:
  - The counter increments each cycle.
  - On the edge where the count equals `SETTLE_CYCLES`-1, `alu_out` is captured into `rsp_data`, `rsp_err` is cleared, and the state moves to RESP.
- RESP:
  - `rsp_valid` is high.
  - `rsp_data`, `rsp_id` and `rsp_err` stay stable until the edge with `rsp_ready` high, which returns the state to IDLE.
- Requesters hold their payload stable while valid and not ready. Dropping valid before acceptance is legal; nothing is accepted.
- `alu_in_*` and `alu_sel` keep their last values outside EXEC.

## Timing

- Reset values, all applied immediately on `rst`:
  - Every output is 0: both ready signals, `rsp_*`, `alu_*` and `busy`.
  - State is IDLE, the counter is 0 and `last_grant` is 1.
- Accept on edge N gives:
  - `alu_en` high during cycles N..N+`SETTLE_CYCLES`-1.
  - Capture at edge N+`SETTLE_CYCLES`.
  - `rsp_valid` high from that edge.
- Illegal opcode: `rsp_valid` is high from edge N+1.
- With `rsp_ready` held high:
  - Return to IDLE at edge N+`SETTLE_CYCLES`+1.
  - Next accept no earlier than edge N+`SETTLE_CYCLES`+2.
  - Sustained throughput is one operation per `SETTLE_CYCLES`+2 cycles.
- No request is accepted outside IDLE. Both ready signals are low in EXEC and RESP.
- Reset during EXEC or RESP aborts the operation and discards the response. Requesters must reissue.

## Structure

- Package `alu_ctrl_pkg` holds:
  - State encoding: IDLE=0, EXEC=1, RESP=2.
  - `OP_W`=3, `DATA_W`=4, `OP_MAX`=3.
- Sub-module `rr_arbiter2` contains the two-input round-robin grant and the `last_grant` register, with an update strobe driven on accept.
- The top level holds the FSM, settle counter, payload registers and response registers.

## Test plan

Bench ALU stub: `alu_out` = `alu_in_1` XOR `alu_in_2` when `alu_en` is high, else 0. `SETTLE_CYCLES`=1 unless stated.

- Reset pulse applied mid-simulation -> all outputs 0 in the same cycle; `busy`=0.
- req0 sends a=7, b=5, sel=0 -> ready in the first IDLE cycle; `alu_en` high for 1 cycle; `rsp_data`=2, `rsp_id`=0, `rsp_err`=0 from edge N+1.
- Both valid continuously with req0 (12,1,sel=1) and req1 (5,10,sel=3) -> grants go 0,1,0,1; responses 13 (id 0) and 15 (id 1) alternate; accepts are 3 cycles apart.
- `rsp_ready` held low for 5 cycles after a=10, b=8, sel=2 -> `rsp_valid`=1 and `rsp_data`=2 stay stable; both ready signals stay low; a new accept follows only after `rsp_ready` goes high.
- req1 sends sel=5 -> `rsp_err`=1, `rsp_data`=0, `rsp_id`=1 at N+1; `alu_en` never rises.
- `SETTLE_CYCLES`=3, with reset asserted in the second EXEC cycle -> `alu_en` and `busy` drop at once; no response is issued; a following req1-only request completes normally.
